rs232tx: RTL

- RS232 transmitter: 8N1 framing by default, LSB first, with a small input FIFO.
- Accepts bytes over a valid/ready handshake and serialises them on serial_out at a fixed baud rate.
- Pairs with the existing RS232 receiver as the transmit half of the console UART.
- Unlike the receiver, it applies backpressure through ready, so bytes are never lost.

---
 rtl/rs232tx.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/rs232tx.sv
`default_nettype none
// ============================================================================
// Module   : rs232tx
// Purpose  : RS232 transmitter, 8 data bits, no parity, STOP_BITS stop bits,
//            LSB first. Bytes enter a small circular FIFO over a valid/ready
//            handshake and are serialised at a fixed baud rate.
// Revision : 1.0 - initial release
// ============================================================================
module rs232tx #(
   parameter int frequency   = 25_000_000,
   parameter int bps         = 57_600,
   parameter int period      = (frequency + bps / 2) / bps,
   parameter int TTYCLK_SIGN = 20,
   parameter int FIFO_LOG2   = 2,
   parameter int STOP_BITS   = 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [7:0]           data,
   input  logic                 valid,
   output logic                 ready,
   output logic                 serial_out,
   output logic                 busy,
   output logic [FIFO_LOG2:0]   level
);

   localparam int c_depth = 1 << FIFO_LOG2;

   localparam logic [FIFO_LOG2:0]   c_ptr_one   = (FIFO_LOG2 + 1)'(1);
   localparam logic [FIFO_LOG2:0]   c_full_xor  = {1'b1, {FIFO_LOG2{1'b0}}};
   localparam logic [TTYCLK_SIGN:0] c_bit_load  = (TTYCLK_SIGN + 1)'(period - 2);
   localparam logic [TTYCLK_SIGN:0] c_stop_load = (TTYCLK_SIGN + 1)'(STOP_BITS * period - 2);
   localparam logic [TTYCLK_SIGN:0] c_timer_one = (TTYCLK_SIGN + 1)'(1);

   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_start = 2'd1;
   localparam logic [1:0] c_st_data  = 2'd2;
   localparam logic [1:0] c_st_stop  = 2'd3;

   logic [7:0]           r_mem [c_depth];
   logic [FIFO_LOG2:0]   r_wr_ptr;
   logic [FIFO_LOG2:0]   r_rd_ptr;
   logic [1:0]           r_state;
   logic [TTYCLK_SIGN:0] r_timer;
   logic [7:0]           r_shift;
   logic [2:0]           r_bitcnt;
   logic                 r_serial;

   logic [FIFO_LOG2:0]   w_level;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_expired;
   logic [7:0]           w_head;

   // Occupancy and flags derive purely from the pointers, so ready never sees valid.
   assign w_level   = r_wr_ptr - r_rd_ptr;
   assign w_full    = ((r_wr_ptr ^ r_rd_ptr) == c_full_xor);
   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign w_expired = r_timer[TTYCLK_SIGN];
   assign w_head    = r_mem[r_rd_ptr[FIFO_LOG2-1:0]];
   assign w_push    = valid & ~w_full;
   // A new frame is loaded from IDLE, or straight out of an expiring stop bit.
   assign w_pop     = ~w_empty &
                      ((r_state == c_st_idle) | ((r_state == c_st_stop) & w_expired));

   assign ready      = ~w_full;
   assign level      = w_level;
   assign serial_out = r_serial;
   assign busy       = (r_state != c_st_idle) | (w_level != '0);

   // FIFO storage: written on accepted transfers; contents need no reset.
   always_ff @(posedge clock) begin
      if (w_push && !reset) begin
         r_mem[r_wr_ptr[FIFO_LOG2-1:0]] <= data;
      end
   end

   // FIFO pointers advance on push and pop independently; reset discards everything.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
         end
      end
   end

   // Frame sequencer: start bit, eight data bits LSB first, then stop bit(s).
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= c_st_idle;
         r_timer  <= '0;
         r_shift  <= '0;
         r_bitcnt <= '0;
         r_serial <= 1'b1;
      end else if (w_pop) begin
         r_state  <= c_st_start;
         r_shift  <= w_head;
         r_timer  <= c_bit_load;
         r_bitcnt <= 3'd7;
         r_serial <= 1'b0;
      end else begin
         case (r_state)
            c_st_idle: begin
               r_serial <= 1'b1;
            end
            c_st_start: begin
               if (w_expired) begin
                  r_state  <= c_st_data;
                  r_serial <= r_shift[0];
                  r_shift  <= {1'b0, r_shift[7:1]};
                  r_timer  <= c_bit_load;
               end else begin
                  r_timer <= r_timer - c_timer_one;
               end
            end
            c_st_data: begin
               if (w_expired) begin
                  if (r_bitcnt != 3'd0) begin
                     r_serial <= r_shift[0];
                     r_shift  <= {1'b0, r_shift[7:1]};
                     r_bitcnt <= r_bitcnt - 3'd1;
                     r_timer  <= c_bit_load;
                  end else begin
                     r_state  <= c_st_stop;
                     r_serial <= 1'b1;
                     r_timer  <= c_stop_load;
                  end
               end else begin
                  r_timer <= r_timer - c_timer_one;
               end
            end
            c_st_stop: begin
               // Non-empty expiry is handled by the pop branch above.
               if (w_expired) begin
                  r_state <= c_st_idle;
               end else begin
                  r_timer <= r_timer - c_timer_one;
               end
            end
            default: begin
               r_state  <= c_st_idle;
               r_serial <= 1'b1;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
